// File: rtl/byte_serial_subtractor_pkg.sv
// Shared definitions for the byte-serial subtractor: state encoding, default
// geometry and the slice-index width helper.
package byte_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF  = 32;
  localparam int SLICE_DEF  = 8;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NSLICE_DEF);

endpackage

// File: rtl/byte_serial_subtractor_sub_slice8.sv
// Combinational SLICE-bit ripple subtractor built from full-subtractor cells:
// {bout, d} = x - y - bin.
module sub_slice8 #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fs
    assign d[i]       = x[i] ^ y[i] ^ brw[i];
    assign brw[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign bout = brw[SLICE];

endmodule

// File: rtl/byte_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per cycle,
// LSB first, with the borrow carried between slices in a register.
module byte_serial_subtractor
  import byte_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_width(NSLICE);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               brw_q, brw_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   sx, sy, sd;
  logic               sbo;
  logic               accept;
  logic               last;

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == IDX_W'(NSLICE - 1));

  assign sx = a_q[idx_q*SLICE +: SLICE];
  assign sy = b_q[idx_q*SLICE +: SLICE];

  sub_slice8 #(.SLICE(SLICE)) u_slice (
    .x    (sx),
    .y    (sy),
    .bin  (brw_q),
    .d    (sd),
    .bout (sbo)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          idx_d   = '0;
          brw_d   = bin;
        end
      end
      ST_RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = sd;
        brw_d = sbo;
        idx_d = idx_q + 1'b1;
        // Flags are taken from the fully assembled result on the final slice.
        if (last) begin
          state_d = ST_DONE;
          bout_d  = sbo;
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operands are pure data; they only need to be valid after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/byte_serial_subtractor.md
Name: byte_serial_subtractor

Overview:
- Multi-cycle 32-bit subtractor, the inverse-direction companion to the team's carry-increment adder. Computes diff = A - B - bin.
- One 8-bit ripple-subtract slice is reused over 4 cycles, LSB slice first. The borrow is registered between slices.
- Valid/ready handshake on input and output.
- Used where area matters more than latency, e.g. address/pointer difference in control paths.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE (4 by default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  A - B - bin, modulo 2^WIDTH
- bout  out  1  final borrow; 1 iff unsigned A < B + bin
- zero  out  1  diff == 0
- ovf  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- While rst_n=0 at a clock edge, the edge sets:
  - state=IDLE, slice index=0, borrow register=0
  - diff=0, bout=0, zero=0, ovf=0, out_valid=0
  - in_ready is forced 0 while rst_n is low.
- A reset mid-RUN or in DONE discards the operation; no result is produced.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a, b; load the borrow register with bin; set index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: {borrow_next, d} = a_slice[idx] - b_slice[idx] - borrow_reg.
  - d is written to diff[idx*SLICE +: SLICE]; other slices hold; borrow_reg <= borrow_next; idx++.
  - After the idx==NSLICE-1 cycle: go to DONE.
  - Latency: accept edge k, RUN edges k+1..k+4, out_valid=1 after edge k+4.
- DONE:
  - out_valid=1; diff, bout (= final borrow), zero and ovf are stable.
  - On out_ready=1: go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
  - out_ready=0 holds DONE indefinitely with all outputs unchanged.
- Operand changes on a/b/bin outside the accept cycle are ignored.
- in_valid while in RUN or DONE is ignored; the source must hold it until in_ready.
- Timing of flags: zero, ovf and bout update only on entry to DONE. They hold their last values in IDLE (0 after reset).
- Borrow propagates across slice boundaries only through the registered borrow, one slice per cycle.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), WIDTH/SLICE defaults, NSLICE constant, index width = clog2(NSLICE).
- One sub-module: sub_slice8.
  - Combinational SLICE-bit ripple subtractor with inputs x, y, bin and outputs d, bout.
  - Built from full-subtractor cells, mirroring the adder slice style.
- FSM, operand registers and result assembly live in the top.

Test Plan:
- Single step: a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, zero=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Borrow chain: a=0x00000100, b=0x00000001 -> diff=0x000000FF, bout=0, proving borrow crosses the slice 0 to slice 1 boundary. Also a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, bout=1, ovf=0.
- Signed overflow and borrow-in:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, bout=0.
  - a=0x12345678, b=0x12345677, bin=1 -> diff=0x00000000, zero=1, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs unchanged, in_ready=0. A new in_valid with a=0xFFFFFFFF is ignored. Release -> IDLE next cycle, then the new operand is accepted.
- Reset mid-RUN: drive rst_n=0 on the 2nd RUN cycle -> next edge state=IDLE, out_valid=0, diff=0, in_ready=0 while low. After release, in_ready=1 and a fresh operation completes correctly.
- Randomised back-to-back regression: 1000 random a/b/bin with random out_ready stalls -> every result matches a 33-bit reference subtraction; bout = bit 32 of the reference result.
